rob_commit_unit: RTL
====================

Name: rob_commit_unit

Overview:
- In-order retirement stage directly downstream of the ROB.
- Watches the ROB head and pops it once the result is ready.
- Turns each retired instruction into an architectural register-file write through a valid/ready write-back port.
- Tracks the retired-instruction count and stops retiring permanently after a halt instruction.

Parameters:
- DATA_W, 32, width of instruction word and result value.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- rob_is_empty  in  1  ROB has no valid entries.
- rob_head_ready  in  1  ROB head entry has its result.
- rob_head_instr  in  DATA_W  instruction word at the ROB head.
- rob_head_val  in  DATA_W  result value at the ROB head.
- rob_pop  out  1  combinational; ROB removes its head at this clock edge.
- wb_valid  out  1  architectural write pending.
- wb_addr  out  5  destination register.
- wb_data  out  DATA_W  value to write.
- wb_ready  in  1  register file accepts the write this cycle.
- retired_count  out  CNT_W  number of instructions retired since reset.
- halted  out  1  a halt instruction has retired.

Behaviour:
- Decode uses the team ISA fields: opcode = instr[31:27], rd = instr[26:22].
- Destination rules:
  - opcodes 00000 (ALU), 00101 (addi), 01000 (lw): write rd.
  - 00011 (jal): write r31.
  - 10101 (setx): write r30.
  - All other opcodes: no register write.
  - Any write whose destination is r0 is treated as no-write.
- Halt = opcode 11111. It causes no register write.
- Head eligible = !rob_is_empty && rob_head_ready && !halted.
- FSM, two states:
  - IDLE: no write held. wb_valid=0.
  - HOLD: one write captured in wb_addr/wb_data. wb_valid=1.
- In IDLE:
  - If head eligible: rob_pop=1 and retired_count increments.
  - If the head is a writing instr, capture addr/data and go to HOLD. Otherwise stay in IDLE.
- In HOLD:
  - wb_valid stays high and wb_addr/wb_data stay stable until wb_ready=1.
  - If wb_ready=1 and the head is eligible in the same cycle: the current write drains and the next head is popped the same cycle, so back-to-back retirement reaches 1 instr/cycle.
    - Next head is a writing instr: stay in HOLD with the new addr/data.
    - Next head is not a writing instr: go to IDLE.
  - If wb_ready=1 and the head is not eligible: go to IDLE.
  - If wb_ready=0: rob_pop=0; no new head is popped.
- Halt:
  - Popping a halt sets halted=1 at the next edge. halted is sticky until reset.
  - A write already in HOLD still drains after halt.
  - No further pops while halted=1.
- rob_pop is a pure function of state and inputs. It is never asserted when rob_is_empty=1 or rob_head_ready=0.
- retired_count:
  - Counts every pop, halt included.
  - Wraps modulo 2^CNT_W.
- Latency: head eligible at cycle N means pop at edge N and wb_valid=1 in cycle N+1.
- Reset (synchronous): state=IDLE, wb_valid=0, wb_addr=0, wb_data=0, retired_count=0, halted=0.
  - Reset mid-HOLD discards the pending write.
  - rob_pop=0 during any cycle with reset=1.

Test Plan:
- ALU to r5, then addi to r7, head ready back-to-back, wb_ready=1 → rob_pop high 2 consecutive cycles; wb (5,val0) then (7,val1) on consecutive cycles; retired_count=2.
- add r3 retired, wb_ready held 0 for 3 cycles while the next head (r4) is ready → wb_addr=3 stable, rob_pop=0 for 3 cycles; on wb_ready=1, pop r4 the same cycle; wb_addr=4 the next cycle.
- Heads sw, bne, then add writing r0 → 3 pops, wb_valid never asserted, retired_count=3.
- jal and setx → wb_addr=31 then 30 with the respective head_val.
- add r9, then halt, then add r2, all ready → r9 written, halted=1 after the halt pop, r2 never popped, retired_count=2.
- Reset asserted while in HOLD with wb_ready=0 → next cycle wb_valid=0, retired_count=0, halted=0, rob_pop=0.

Source files
------------

// File: rtl/rob_commit_unit.sv
// In-order retirement stage sitting directly behind the ROB.
// Pops the ROB head once its result is ready, turns each retired instruction
// into one architectural register-file write over a valid/ready port, counts
// retirements and stops retiring for good once a halt instruction retires.
module rob_commit_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rob_is_empty,
    input  logic              rob_head_ready,
    input  logic [DATA_W-1:0] rob_head_instr,
    input  logic [DATA_W-1:0] rob_head_val,
    output logic              rob_pop,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic              wb_ready,
    output logic [CNT_W-1:0]  retired_count,
    output logic              halted
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // Maps {opcode, rd} to {write_enable, dest_reg}; r0 destinations never write.
    function automatic logic [5:0] dest_decode(input logic [4:0] op, input logic [4:0] rd);
        logic       we;
        logic [4:0] addr;
        we   = 1'b0;
        addr = 5'd0;
        case (op)
            OP_ALU, OP_ADDI, OP_LW: begin
                we   = 1'b1;
                addr = rd;
            end
            OP_JAL: begin
                we   = 1'b1;
                addr = 5'd31;
            end
            OP_SETX: begin
                we   = 1'b1;
                addr = 5'd30;
            end
            default: begin
                we   = 1'b0;
                addr = 5'd0;
            end
        endcase
        if (addr == 5'd0) begin
            we = 1'b0;
        end
        return {we, addr};
    endfunction

    state_t      state;
    logic [5:0]  head_dest;
    logic        head_we;
    logic [4:0]  head_addr;
    logic        head_halt;
    logic        head_eligible;
    logic        unused_instr_bits;

    // Only the opcode/rd fields matter here; the rest of the word is ignored.
    assign unused_instr_bits = ^rob_head_instr;

    // Head decode and pop decision; a held write must drain before the next pop.
    always_comb begin
        head_dest     = dest_decode(rob_head_instr[31:27], rob_head_instr[26:22]);
        head_we       = head_dest[5];
        head_addr     = head_dest[4:0];
        head_halt     = (rob_head_instr[31:27] == OP_HALT);
        head_eligible = !rob_is_empty && rob_head_ready && !halted;
        rob_pop       = !reset && head_eligible && ((state == IDLE) || wb_ready);
    end

    // Retirement FSM: captures writes, drains them, counts pops and latches halt.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            wb_valid      <= 1'b0;
            wb_addr       <= 5'd0;
            wb_data       <= '0;
            retired_count <= '0;
            halted        <= 1'b0;
        end else begin
            if (rob_pop) begin
                retired_count <= retired_count + CNT_W'(1);
                if (head_halt) begin
                    halted <= 1'b1;
                end
                if (head_we) begin
                    state    <= HOLD;
                    wb_valid <= 1'b1;
                    wb_addr  <= head_addr;
                    wb_data  <= rob_head_val;
                end else begin
                    state    <= IDLE;
                    wb_valid <= 1'b0;
                end
            end else if ((state == HOLD) && wb_ready) begin
                state    <= IDLE;
                wb_valid <= 1'b0;
            end
        end
    end

endmodule
